// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared constants for the execute-stage arithmetic datapath.
//   - ALU opcode constants ALUOP_ADD .. ALUOP_LUI (4-bit codes; 0xE/0xF
//     are reserved and produce a zero result).
//   - Operand A select: ALU_A_SEL_REG / ALU_A_SEL_PC.
//   - Operand B select: ALU_B_SEL_REG / IMM16 / IMM22 / ONE.
//   - Sign-extension helpers for the two raw immediate formats.
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam int ALU_W = 32;
    localparam int PC_W  = 30;

    localparam logic [3:0] ALUOP_ADD  = 4'h0;
    localparam logic [3:0] ALUOP_SUB  = 4'h1;
    localparam logic [3:0] ALUOP_AND  = 4'h2;
    localparam logic [3:0] ALUOP_OR   = 4'h3;
    localparam logic [3:0] ALUOP_XOR  = 4'h4;
    localparam logic [3:0] ALUOP_LSL  = 4'h5;
    localparam logic [3:0] ALUOP_LSR  = 4'h6;
    localparam logic [3:0] ALUOP_ASR  = 4'h7;
    localparam logic [3:0] ALUOP_MOV  = 4'h8;
    localparam logic [3:0] ALUOP_MVN  = 4'h9;
    localparam logic [3:0] ALUOP_SEQ  = 4'hA;
    localparam logic [3:0] ALUOP_SLT  = 4'hB;
    localparam logic [3:0] ALUOP_SLTU = 4'hC;
    localparam logic [3:0] ALUOP_LUI  = 4'hD;

    localparam logic ALU_A_SEL_REG = 1'b0;
    localparam logic ALU_A_SEL_PC  = 1'b1;

    localparam logic [1:0] ALU_B_SEL_REG   = 2'b00;
    localparam logic [1:0] ALU_B_SEL_IMM16 = 2'b01;
    localparam logic [1:0] ALU_B_SEL_IMM22 = 2'b10;
    localparam logic [1:0] ALU_B_SEL_ONE   = 2'b11;

    function automatic logic [ALU_W-1:0] sext16(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

    function automatic logic [ALU_W-1:0] sext22(input logic [21:0] imm);
        return {{10{imm[21]}}, imm};
    endfunction

endpackage

// File: rtl/alu_datapath_if.sv
// ---------------------------------------------------------------------------
// alu_datapath_if
// Bundles the decode-side operation inputs and the memory-side registered
// outputs of alu_datapath.
//   master : driver of the operation (decode stage / testbench)
//   slave  : the datapath itself
// Signals:
//   stall_i  hold all output registers
//   valid_i  operation present this cycle
//   aluop_i  4-bit opcode
//   a_sel_i  operand A select (reg / PC)
//   b_sel_i  operand B select (reg / imm16 / imm22 / one)
//   reg_a_i, reg_b_i, pc_i, imm16_i, imm22_i  operand sources
//   alu_o, zero_o, valid_o  registered result, result==0, registered valid
// Handshake: valid_i qualifies the operation; there is no back-pressure
// other than stall_i. valid_o tells the consumer whether alu_o is meaningful.
// ---------------------------------------------------------------------------
interface alu_datapath_if;
    import alu_pkg::*;

    logic              stall_i;
    logic              valid_i;
    logic [3:0]        aluop_i;
    logic              a_sel_i;
    logic [1:0]        b_sel_i;
    logic [ALU_W-1:0]  reg_a_i;
    logic [ALU_W-1:0]  reg_b_i;
    logic [PC_W-1:0]   pc_i;
    logic [15:0]       imm16_i;
    logic [21:0]       imm22_i;
    logic [ALU_W-1:0]  alu_o;
    logic              zero_o;
    logic              valid_o;

    modport master (
        output stall_i, valid_i, aluop_i, a_sel_i, b_sel_i,
               reg_a_i, reg_b_i, pc_i, imm16_i, imm22_i,
        input  alu_o, zero_o, valid_o
    );

    modport slave (
        input  stall_i, valid_i, aluop_i, a_sel_i, b_sel_i,
               reg_a_i, reg_b_i, pc_i, imm16_i, imm22_i,
        output alu_o, zero_o, valid_o
    );

endinterface

// File: rtl/alu_core.sv
// ---------------------------------------------------------------------------
// alu_core
// Purely combinational ALU: (op, a, b) -> result. All arithmetic is modulo
// 2^32; carries and overflow are dropped. Compares return 1 or 0.
// Build option: ALU_SHIFT_EN. When defined, opcodes LSL/LSR/ASR shift by
// b[4:0]. When undefined, the barrel shifter is not built and those opcodes
// fall into the reserved path (result 0).
// Ports:
//   op_i      4-bit opcode
//   a_i, b_i  32-bit operands
//   result_o  32-bit result
// ---------------------------------------------------------------------------
module alu_core
    import alu_pkg::*;
(
    input  logic [3:0]       op_i,
    input  logic [ALU_W-1:0] a_i,
    input  logic [ALU_W-1:0] b_i,
    output logic [ALU_W-1:0] result_o
);

    always_comb begin
        result_o = '0;
        case (op_i)
            ALUOP_ADD:  result_o = a_i + b_i;
            ALUOP_SUB:  result_o = a_i - b_i;
            ALUOP_AND:  result_o = a_i & b_i;
            ALUOP_OR:   result_o = a_i | b_i;
            ALUOP_XOR:  result_o = a_i ^ b_i;
`ifdef ALU_SHIFT_EN
            ALUOP_LSL:  result_o = a_i << b_i[4:0];
            ALUOP_LSR:  result_o = a_i >> b_i[4:0];
            ALUOP_ASR:  result_o = $unsigned($signed(a_i) >>> b_i[4:0]);
`endif
            ALUOP_MOV:  result_o = b_i;
            ALUOP_MVN:  result_o = ~b_i;
            ALUOP_SEQ:  result_o = (a_i == b_i) ? 32'd1 : 32'd0;
            ALUOP_SLT:  result_o = ($signed(a_i) < $signed(b_i)) ? 32'd1 : 32'd0;
            ALUOP_SLTU: result_o = (a_i < b_i) ? 32'd1 : 32'd0;
            ALUOP_LUI:  result_o = {b_i[15:0], 16'h0000};
            // 0xE, 0xF (and shifts without the shifter) are reserved: zero.
            default:    result_o = '0;
        endcase
    end

endmodule

// File: rtl/alu_datapath.sv
// ---------------------------------------------------------------------------
// alu_datapath
// Execute-stage arithmetic datapath. Selects operand A (register or
// zero-extended word PC) and operand B (register, sign-extended imm16,
// sign-extended imm22, or constant 1), runs them through alu_core, and
// registers result, zero flag and valid for the memory stage.
// Latency 1 cycle, one operation per cycle.
// Build option: ALU_SHIFT_EN (see alu_core).
// Ports:
//   clk_i  clock, rising edge
//   rst_i  synchronous active-high reset (alu_o=0, zero_o=1, valid_o=0);
//          wins over stall
//   bus    alu_datapath_if.slave: operation inputs and registered outputs
// The result is captured even when valid_i is low; only valid_o marks it.
// ---------------------------------------------------------------------------
module alu_datapath
    import alu_pkg::*;
(
    input  logic           clk_i,
    input  logic           rst_i,
    alu_datapath_if.slave  bus
);

    logic [ALU_W-1:0] op_a;
    logic [ALU_W-1:0] op_b;
    logic [ALU_W-1:0] result;

    logic [ALU_W-1:0] alu_d, alu_q;
    logic             zero_d, zero_q;
    logic             valid_d, valid_q;

    // Operand selection
    always_comb begin
        op_a = (bus.a_sel_i == ALU_A_SEL_PC) ? {2'b00, bus.pc_i} : bus.reg_a_i;
        op_b = bus.reg_b_i;
        case (bus.b_sel_i)
            ALU_B_SEL_REG:   op_b = bus.reg_b_i;
            ALU_B_SEL_IMM16: op_b = sext16(bus.imm16_i);
            ALU_B_SEL_IMM22: op_b = sext22(bus.imm22_i);
            ALU_B_SEL_ONE:   op_b = 32'd1;
            default:         op_b = bus.reg_b_i;
        endcase
    end

    alu_core u_core (
        .op_i     (bus.aluop_i),
        .a_i      (op_a),
        .b_i      (op_b),
        .result_o (result)
    );

    // Stall holds every output register; otherwise capture this cycle's op.
    always_comb begin
        alu_d   = alu_q;
        zero_d  = zero_q;
        valid_d = valid_q;
        if (!bus.stall_i) begin
            alu_d   = result;
            zero_d  = (result == '0);
            valid_d = bus.valid_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            alu_q   <= '0;
            zero_q  <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            alu_q   <= alu_d;
            zero_q  <= zero_d;
            valid_q <= valid_d;
        end
    end

    assign bus.alu_o   = alu_q;
    assign bus.zero_o  = zero_q;
    assign bus.valid_o = valid_q;

endmodule

// File: tb/tb_alu_datapath.sv
// ---------------------------------------------------------------------------
// tb_alu_datapath
// Self-checking bench for alu_datapath: directed vector table, hand-written
// stall/reset sequences, and randomized operations checked against a
// behavioural model computed with plain integer arithmetic.
// ---------------------------------------------------------------------------
module tb_alu_datapath;
    import alu_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_datapath_if bus ();

    alu_datapath dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    // {valid, zero, alu} expected per captured cycle
    logic [33:0] exp_q[$];

    // ---------------- checking ----------------
    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic check_out(input string name, input logic [33:0] exp);
        check32({name, "_alu"}, bus.alu_o, exp[31:0]);
        check32({name, "_zero"}, {31'b0, bus.zero_o}, {31'b0, exp[32]});
        check32({name, "_valid"}, {31'b0, bus.valid_o}, {31'b0, exp[33]});
    endtask

    // ---------------- driver ----------------
    task automatic drive(input logic [3:0] op, input logic a_sel, input logic [1:0] b_sel,
                         input logic [31:0] ra, input logic [31:0] rb, input logic [29:0] pc,
                         input logic [15:0] i16, input logic [21:0] i22,
                         input logic v, input logic stall);
        bus.aluop_i = op;
        bus.a_sel_i = a_sel;
        bus.b_sel_i = b_sel;
        bus.reg_a_i = ra;
        bus.reg_b_i = rb;
        bus.pc_i    = pc;
        bus.imm16_i = i16;
        bus.imm22_i = i22;
        bus.valid_i = v;
        bus.stall_i = stall;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    localparam longint TWO32 = 64'd4294967296;

    function automatic longint as_signed(input longint u);
        return (u >= 64'd2147483648) ? u - TWO32 : u;
    endfunction

    function automatic logic [31:0] model_b(input logic [1:0] b_sel, input logic [31:0] rb,
                                            input logic [15:0] i16, input logic [21:0] i22);
        longint v16, v22;
        v16 = longint'(i16);
        v22 = longint'(i22);
        case (b_sel)
            2'd0:    return rb;
            2'd1:    return (v16 >= 32768)   ? 32'(v16 + TWO32 - 65536)   : 32'(v16);
            2'd2:    return (v22 >= 2097152) ? 32'(v22 + TWO32 - 4194304) : 32'(v22);
            default: return 32'd1;
        endcase
    endfunction

    function automatic logic [31:0] model_alu(input logic [3:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        longint ua, ub, sa, sb, p;
        int n;
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        sa = as_signed(ua);
        sb = as_signed(ub);
        n  = int'(ub % 32);
        p  = 64'd1 << n;
        case (op)
            4'd0:  return 32'((ua + ub) % TWO32);
            4'd1:  return 32'((ua - ub + TWO32) % TWO32);
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  return a ^ b;
`ifdef ALU_SHIFT_EN
            4'd5:  return 32'((ua * p) % TWO32);
            4'd6:  return 32'(ua / p);
            4'd7:  return (sa >= 0) ? 32'(sa / p) : 32'(((sa - (p - 1)) / p) + TWO32);
`endif
            4'd8:  return b;
            4'd9:  return 32'(TWO32 - 1 - ub);
            4'd10: return (ua == ub) ? 32'd1 : 32'd0;
            4'd11: return (sa < sb) ? 32'd1 : 32'd0;
            4'd12: return (ua < ub) ? 32'd1 : 32'd0;
            4'd13: return 32'((ub * 65536) % TWO32);
            default: return 32'd0;
        endcase
    endfunction

    // ---------------- directed table ----------------
    typedef struct {
        logic [3:0]  op;
        logic        a_sel;
        logic [1:0]  b_sel;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [29:0] pc;
        logic [15:0] i16;
        logic [21:0] i22;
        logic        v;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [3:0] op, input logic a_sel, input logic [1:0] b_sel,
                                input logic [31:0] ra, input logic [31:0] rb, input logic [29:0] pc,
                                input logic [15:0] i16, input logic [21:0] i22,
                                input logic v, input logic [31:0] exp);
        vec_t r;
        r.op = op; r.a_sel = a_sel; r.b_sel = b_sel; r.ra = ra; r.rb = rb;
        r.pc = pc; r.i16 = i16; r.i22 = i22; r.v = v; r.exp = exp;
        return r;
    endfunction

    logic [33:0] prev;
    logic [33:0] e;
    logic [31:0] a_m, b_m, r_m;
    logic        stall_r, rst_r;

    initial begin
        // ---- reset with stall asserted ----
        rst = 1'b1;
        drive(4'h0, 1'b0, 2'd0, 32'h1234, 32'h1, 30'h0, 16'h0, 22'h0, 1'b1, 1'b1);
        tick();
        check_out("reset", {1'b0, 1'b1, 32'h0});
        rst = 1'b0;

        // ---- vector table ----
        vecs.push_back(mk(4'h0, 1'b1, 2'd3, 32'h0, 32'h0, 30'h3FFFFFFF, 16'h0, 22'h0, 1'b1, 32'h40000000));
        vecs.push_back(mk(4'h0, 1'b1, 2'd3, 32'hFFFF, 32'h0, 30'd5, 16'h0, 22'h0, 1'b1, 32'd6));
        vecs.push_back(mk(4'h0, 1'b0, 2'd1, 32'h0, 32'h0, 30'h0, 16'h8000, 22'h0, 1'b1, 32'hFFFF8000));
        vecs.push_back(mk(4'h0, 1'b0, 2'd2, 32'h0, 32'h0, 30'h0, 16'h0, 22'h200000, 1'b1, 32'hFFE00000));
        vecs.push_back(mk(4'h0, 1'b0, 2'd1, 32'h0, 32'h0, 30'h0, 16'h7FFF, 22'h0, 1'b1, 32'h00007FFF));
        vecs.push_back(mk(4'h1, 1'b0, 2'd0, 32'h0, 32'h1, 30'h0, 16'h0, 22'h0, 1'b1, 32'hFFFFFFFF));
        vecs.push_back(mk(4'h1, 1'b0, 2'd0, 32'd5, 32'd5, 30'h0, 16'h0, 22'h0, 1'b1, 32'h0));
        vecs.push_back(mk(4'hB, 1'b0, 2'd0, 32'hFFFFFFFF, 32'd1, 30'h0, 16'h0, 22'h0, 1'b1, 32'd1));
        vecs.push_back(mk(4'hC, 1'b0, 2'd0, 32'hFFFFFFFF, 32'd1, 30'h0, 16'h0, 22'h0, 1'b1, 32'd0));
`ifdef ALU_SHIFT_EN
        vecs.push_back(mk(4'h7, 1'b0, 2'd0, 32'h80000000, 32'h21, 30'h0, 16'h0, 22'h0, 1'b1, 32'hC0000000));
        vecs.push_back(mk(4'h5, 1'b0, 2'd0, 32'h1, 32'd31, 30'h0, 16'h0, 22'h0, 1'b1, 32'h80000000));
        vecs.push_back(mk(4'h6, 1'b0, 2'd0, 32'h80000000, 32'd4, 30'h0, 16'h0, 22'h0, 1'b1, 32'h08000000));
`else
        vecs.push_back(mk(4'h7, 1'b0, 2'd0, 32'h80000000, 32'h21, 30'h0, 16'h0, 22'h0, 1'b1, 32'h0));
        vecs.push_back(mk(4'h5, 1'b0, 2'd0, 32'h1, 32'd31, 30'h0, 16'h0, 22'h0, 1'b1, 32'h0));
        vecs.push_back(mk(4'h6, 1'b0, 2'd0, 32'h80000000, 32'd4, 30'h0, 16'h0, 22'h0, 1'b1, 32'h0));
`endif
        vecs.push_back(mk(4'h0, 1'b0, 2'd3, 32'h7FFFFFFF, 32'h0, 30'h0, 16'h0, 22'h0, 1'b1, 32'h80000000));
        vecs.push_back(mk(4'h8, 1'b0, 2'd1, 32'h0, 32'h0, 30'h0, 16'h1234, 22'h0, 1'b1, 32'h00001234));
        vecs.push_back(mk(4'h9, 1'b0, 2'd0, 32'h0, 32'h0F0F0000, 30'h0, 16'h0, 22'h0, 1'b1, 32'hF0F0FFFF));
        vecs.push_back(mk(4'hD, 1'b0, 2'd0, 32'h0, 32'hABCD1234, 30'h0, 16'h0, 22'h0, 1'b1, 32'h12340000));
        vecs.push_back(mk(4'hA, 1'b0, 2'd0, 32'hDEAD, 32'hDEAD, 30'h0, 16'h0, 22'h0, 1'b0, 32'd1));
        vecs.push_back(mk(4'h4, 1'b0, 2'd0, 32'hFF00FF00, 32'h0FF00FF0, 30'h0, 16'h0, 22'h0, 1'b0, 32'hF0F0F0F0));
        vecs.push_back(mk(4'hE, 1'b0, 2'd0, 32'h5, 32'h6, 30'h0, 16'h0, 22'h0, 1'b1, 32'h0));
        vecs.push_back(mk(4'hF, 1'b1, 2'd0, 32'h5, 32'h6, 30'h7, 16'h0, 22'h0, 1'b1, 32'h0));

        foreach (vecs[i]) begin
            drive(vecs[i].op, vecs[i].a_sel, vecs[i].b_sel, vecs[i].ra, vecs[i].rb,
                  vecs[i].pc, vecs[i].i16, vecs[i].i22, vecs[i].v, 1'b0);
            tick();
            check_out($sformatf("vec%0d", i), {vecs[i].v, (vecs[i].exp == 32'h0), vecs[i].exp});
        end

        // ---- stall sequence: result 7 held for 3 stalled cycles ----
        drive(4'h0, 1'b0, 2'd0, 32'd3, 32'd4, 30'h0, 16'h0, 22'h0, 1'b1, 1'b0);
        tick();
        check_out("pre_stall", {1'b1, 1'b0, 32'd7});
        for (int k = 0; k < 3; k++) begin
            drive(4'h1, 1'b0, 2'd0, 32'd100 + k, 32'd100 + k, 30'h0, 16'h0, 22'h0, 1'b0, 1'b1);
            tick();
            check_out($sformatf("stall%0d", k), {1'b1, 1'b0, 32'd7});
        end
        drive(4'h0, 1'b0, 2'd0, 32'd10, 32'd20, 30'h0, 16'h0, 22'h0, 1'b1, 1'b0);
        tick();
        check_out("post_stall", {1'b1, 1'b0, 32'd30});

        // ---- reset during a stall ----
        drive(4'h1, 1'b0, 2'd0, 32'd1, 32'd1, 30'h0, 16'h0, 22'h0, 1'b0, 1'b1);
        tick();
        check_out("stall_hold", {1'b1, 1'b0, 32'd30});
        rst = 1'b1;
        tick();
        check_out("mid_stall_reset", {1'b0, 1'b1, 32'h0});
        rst = 1'b0;

        // ---- randomized stream vs. behavioural model ----
        prev = {1'b0, 1'b1, 32'h0};
        for (int i = 0; i < 600; i++) begin
            logic [3:0]  op;
            logic        as, v;
            logic [1:0]  bs;
            logic [31:0] ra, rb;
            logic [29:0] pc;
            logic [15:0] i16;
            logic [21:0] i22;
            op  = 4'($urandom_range(0, 15));
            as  = 1'($urandom_range(0, 1));
            bs  = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            if ($urandom_range(0, 7) == 0) ra = rb;
            if ($urandom_range(0, 9) == 0) ra = 32'h80000000;
            pc  = 30'($urandom);
            i16 = 16'($urandom);
            i22 = 22'($urandom);
            v   = 1'($urandom_range(0, 1));
            stall_r = ($urandom_range(0, 5) == 0);
            rst_r   = ($urandom_range(0, 49) == 0);
            drive(op, as, bs, ra, rb, pc, i16, i22, v, stall_r);
            rst = rst_r;

            a_m = as ? {2'b00, pc} : ra;
            b_m = model_b(bs, rb, i16, i22);
            r_m = model_alu(op, a_m, b_m);
            if (rst_r)        e = {1'b0, 1'b1, 32'h0};
            else if (stall_r) e = prev;
            else              e = {v, (r_m == 32'h0), r_m};
            exp_q.push_back(e);
            prev = e;

            tick();
            check_out($sformatf("rand%0d_op%0h", i, op), exp_q.pop_front());
        end
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
